dm_port_arbiter: RTL and testbench

Sequencing controller that shares the single port of the pipelined CPU's data memory between two requesters: the CPU MEM stage and a DMA/loader port used to preload or dump memory contents. It grants one access at a time with round-robin fairness, drives a fixed-latency memory access, and returns read data with a one-cycle acknowledge pulse. While the CPU is waiting, it raises a stall to freeze the pipeline registers.

---
 rtl/dm_arb_pkg.sv | 25 ++
 rtl/rr_arbiter_2.sv | 36 +++
 rtl/dm_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_dm_port_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// Shared definitions for the data-memory port arbiter.
//   state_t        : arbiter FSM encoding (IDLE, ACCESS, DONE)
//   REQ_CPU/DMA    : requester ids, also the bit index into the request vector
//   DEF_MEM_BYTES  : default data-memory size in bytes
//   DEF_LAT        : default number of enabled cycles per access
//   addr_legal()   : word-aligned and inside 0..mem_bytes-4
package dm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

  localparam int DEF_MEM_BYTES = 128;
  localparam int DEF_LAT       = 2;

  function automatic logic addr_legal(input logic [31:0] addr, input int mem_bytes);
    return (addr[1:0] == 2'b00) && (addr <= 32'(mem_bytes - 4));
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin picker.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   req[1:0]     : request vector, indexed by REQ_CPU / REQ_DMA
//   update       : commit the current grant as the last winner
//   grant        : id of the selected requester (valid when any req is set)
// The last-winner flop resets to DMA so the CPU takes the first tie.
module rr_arbiter_2
  import dm_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req,
  input  logic       update,
  output logic       grant
);

  logic last_q;

  always_comb begin
    grant = REQ_CPU;
    if (req == 2'b11) begin
      grant = ~last_q;          // tie: whoever did not win last time
    end else if (req[REQ_DMA]) begin
      grant = REQ_DMA;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= REQ_DMA;
    end else if (update) begin
      last_q <= grant;
    end
  end

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares the single data-memory port between the CPU MEM stage and a
// DMA/loader port. One access at a time, round-robin on ties, fixed
// memory latency LAT, one-cycle ack per completed access.
//
// Handshake (both ports): the requester raises *_req_i with we/addr/wdata
// stable and holds it until *_ack_o. The ack is a single-cycle pulse;
// err_o in the same cycle marks a rejected (misaligned or out-of-range)
// access. *_rdata_o is valid with the ack and holds until the next ack
// to that port. A granted access completes even if req drops meanwhile.
//
// Ports:
//   clk_i, rst_i                  clock, async active-high reset
//   cpu_req/we/addr/wdata_i       CPU request
//   cpu_rdata_o, cpu_ack_o        CPU response
//   cpu_stall_o                   cpu_req_i & ~cpu_ack_o
//   dma_req/we/addr/wdata_i       DMA request
//   dma_rdata_o, dma_ack_o        DMA response
//   err_o                         qualifies the ack: access rejected
//   mem_en/we/addr/wdata_o        memory port, mem_rdata_i read data
//   dbg_state_o                   current FSM state
module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int LAT       = DEF_LAT,
  parameter int MEM_BYTES = DEF_MEM_BYTES
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_ack_o,
  output logic        cpu_stall_o,
  input  logic        dma_req_i,
  input  logic        dma_we_i,
  input  logic [31:0] dma_addr_i,
  input  logic [31:0] dma_wdata_i,
  output logic [31:0] dma_rdata_o,
  output logic        dma_ack_o,
  output logic        err_o,
  output logic        mem_en_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output state_t      dbg_state_o
);

  localparam int            CW       = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LAT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, who_q, err_q;
  logic [31:0]   addr_q, wdata_q;
  logic [31:0]   cpu_rdata_q, dma_rdata_q;

  logic          grant, update, any_req, load, legal, last_beat;
  logic          sel_we;
  logic [31:0]   sel_addr, sel_wdata;
  logic          rd_load, rd_who;
  logic [31:0]   rd_val;

  rr_arbiter_2 u_rr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .req    ({dma_req_i, cpu_req_i}),
    .update (update),
    .grant  (grant)
  );

  assign any_req   = cpu_req_i | dma_req_i;
  assign sel_we    = (grant == REQ_DMA) ? dma_we_i    : cpu_we_i;
  assign sel_addr  = (grant == REQ_DMA) ? dma_addr_i  : cpu_addr_i;
  assign sel_wdata = (grant == REQ_DMA) ? dma_wdata_i : cpu_wdata_i;
  assign legal     = addr_legal(sel_addr, MEM_BYTES);
  assign load      = (state_q == IDLE) && any_req;
  assign last_beat = (state_q == ACCESS) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    update  = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          update  = 1'b1;
          cnt_d   = '0;
          state_d = legal ? ACCESS : DONE;   // rejected accesses skip memory
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request latch: captured once when leaving IDLE, so the requester may
  // drop or change its inputs while the access is in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_q    <= 1'b0;
      who_q   <= REQ_DMA;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (load) begin
      we_q    <= sel_we;
      who_q   <= grant;
      err_q   <= ~legal;
      addr_q  <= sel_addr;
      wdata_q <= sel_wdata;
    end
  end

  // Read-data update: the winner's register is written exactly once per
  // access, one cycle before its ack. Writes and rejects return zero.
  assign rd_load = (load && !legal) || last_beat;
  assign rd_who  = last_beat ? who_q : grant;
  assign rd_val  = (last_beat && !we_q) ? mem_rdata_i : 32'h0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else if (rd_load) begin
      if (rd_who == REQ_DMA) begin
        dma_rdata_q <= rd_val;
      end else begin
        cpu_rdata_q <= rd_val;
      end
    end
  end

  // Memory strobes decode directly from the state flop so an asynchronous
  // reset removes them without waiting for a clock edge.
  assign mem_en_o    = (state_q == ACCESS);
  assign mem_we_o    = last_beat & we_q;
  assign mem_addr_o  = mem_en_o ? addr_q  : 32'h0;
  assign mem_wdata_o = mem_en_o ? wdata_q : 32'h0;

  assign cpu_ack_o   = (state_q == DONE) && (who_q == REQ_CPU);
  assign dma_ack_o   = (state_q == DONE) && (who_q == REQ_DMA);
  assign err_o       = (state_q == DONE) && err_q;
  assign cpu_stall_o = cpu_req_i & ~cpu_ack_o;
  assign cpu_rdata_o = cpu_rdata_q;
  assign dma_rdata_o = dma_rdata_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dm_port_arbiter.sv
module tb_dm_port_arbiter;
  import dm_arb_pkg::*;

  localparam int LAT       = 2;
  localparam int MEM_BYTES = 128;
  localparam int W         = 66;   // {port, err, rdata[31:0], ack_cycle[31:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [31:0] cpu_rdata, dma_rdata;
  logic        cpu_ack, cpu_stall, dma_ack, err;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  state_t      dbg_state;

  dm_port_arbiter #(.LAT(LAT), .MEM_BYTES(MEM_BYTES)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cpu_req_i   (cpu_req),
    .cpu_we_i    (cpu_we),
    .cpu_addr_i  (cpu_addr),
    .cpu_wdata_i (cpu_wdata),
    .cpu_rdata_o (cpu_rdata),
    .cpu_ack_o   (cpu_ack),
    .cpu_stall_o (cpu_stall),
    .dma_req_i   (dma_req),
    .dma_we_i    (dma_we),
    .dma_addr_i  (dma_addr),
    .dma_wdata_i (dma_wdata),
    .dma_rdata_o (dma_rdata),
    .dma_ack_o   (dma_ack),
    .err_o       (err),
    .mem_en_o    (mem_en),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata),
    .dbg_state_o (dbg_state)
  );

  // ---------------- memory model and cycle counters ----------------
  function automatic logic [31:0] init_word(input int i);
    return (i == 2) ? 32'h1234_5678 : (32'hA500_0000 | 32'(i));
  endfunction

  logic        mem_init;
  logic [31:0] mem [32];
  int          cyc = 0;
  int          en_cnt = 0, we_cnt = 0, ack_cnt = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_word(i);
    end else if (mem_en && mem_we) begin
      mem[mem_addr[6:2]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem_en ? mem[mem_addr[6:2]] : 32'h0;

  always @(negedge clk) begin
    if (mem_en) en_cnt <= en_cnt + 1;
    if (mem_we) we_cnt <= we_cnt + 1;
    if (!rst && (cpu_ack || dma_ack)) ack_cnt <= ack_cnt + 1;
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Waits (bounded) for the next ack on either port and compares it to the
  // oldest expectation: port, err flag, read data and the cycle it arrived.
  task automatic wait_ack(input int max_cycles);
    logic [W-1:0] e, a;
    for (int k = 0; k < max_cycles; k++) begin
      @(negedge clk);
      if (cpu_ack || dma_ack) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL ack_unexpected: ack at cycle %0d with empty queue", cyc);
          return;
        end
        e = exp_q.pop_front();
        a = {dma_ack, err, (dma_ack ? dma_rdata : cpu_rdata), 32'(cyc)};
        if ((cpu_ack && dma_ack) || (a !== e)) begin
          errors++;
          $display("FAIL ack_record: got port=%0d err=%0d rdata=%h cycle=%0d expected port=%0d err=%0d rdata=%h cycle=%0d",
                   a[65], a[64], a[63:32], a[31:0], e[65], e[64], e[63:32], e[31:0]);
        end
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL ack_timeout: no ack within %0d cycles (cycle %0d)", max_cycles, cyc);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic port, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (port == REQ_DMA) begin
      dma_req = req; dma_we = we; dma_addr = addr; dma_wdata = wdata;
    end else begin
      cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    end
  endtask

  task automatic push_exp(input logic port, input logic e_err, input logic [31:0] rd, input int at);
    exp_q.push_back({port, e_err, rd, 32'(at)});
  endtask

  // Single access from an idle arbiter, including memory-strobe counts.
  task automatic do_access(input logic port, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err);
    int n, en0, we0;
    tick();
    n = cyc; en0 = en_cnt; we0 = we_cnt;
    drive(port, 1'b1, we, addr, wdata);
    push_exp(port, exp_err, exp_rd, n + (exp_err ? 1 : LAT + 1));
    wait_ack(12);
    tick();
    drive(port, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("mem_en_cycles", 32'(en_cnt - en0), 32'(exp_err ? 0 : LAT));
    chk("mem_we_cycles", 32'(we_cnt - we0), 32'((we && !exp_err) ? 1 : 0));
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, a0, e0, w0;

    vecs[0] = '{REQ_CPU, 1'b0, 32'd0,          32'h0,         init_word(0), 1'b0};
    vecs[1] = '{REQ_CPU, 1'b0, 32'd6,          32'h0,         32'h0,        1'b1};
    vecs[2] = '{REQ_CPU, 1'b0, 32'd128,        32'h0,         32'h0,        1'b1};
    vecs[3] = '{REQ_CPU, 1'b0, 32'd124,        32'h0,         init_word(31),1'b0};
    vecs[4] = '{REQ_DMA, 1'b1, 32'd124,        32'hCAFE_F00D, 32'h0,        1'b0};
    vecs[5] = '{REQ_DMA, 1'b0, 32'd124,        32'h0,         32'hCAFE_F00D,1'b0};
    vecs[6] = '{REQ_CPU, 1'b1, 32'd5,          32'h1111_2222, 32'h0,        1'b1};
    vecs[7] = '{REQ_DMA, 1'b0, 32'hFFFF_FFFC,  32'h0,         32'h0,        1'b1};
    vecs[8] = '{REQ_CPU, 1'b0, 32'd4,          32'h0,         32'hDEAD_BEEF,1'b0};
    vecs[9] = '{REQ_DMA, 1'b0, 32'd125,        32'h0,         32'h0,        1'b1};

    rst = 1'b1; mem_init = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
    repeat (2) @(posedge clk);
    #1 mem_init = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_state",     32'(dbg_state), 32'(IDLE));
    chk("rst_acks",      {30'h0, cpu_ack, dma_ack}, 32'h0);
    chk("rst_err",       32'(err), 32'h0);
    chk("rst_mem_en_we", {30'h0, mem_en, mem_we}, 32'h0);
    chk("rst_mem_addr",  mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk("rst_dma_rdata", dma_rdata, 32'h0);
    chk("rst_stall",     32'(cpu_stall), 32'h0);
    tick();
    rst = 1'b0;

    // CPU read of addr 8: stall n..n+2, ack with data at n+3
    tick();
    n = cyc;
    drive(REQ_CPU, 1'b1, 1'b0, 32'd8, 32'h0);
    push_exp(REQ_CPU, 1'b0, 32'h1234_5678, n + 3);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_while_waiting", 32'(cpu_stall), 32'h1);
      tick();
    end
    wait_ack(2);
    chk("stall_at_ack", 32'(cpu_stall), 32'h0);
    tick();
    drive(REQ_CPU, 1'b0, 1'b0, 32'h0, 32'h0);

    // DMA write of DEADBEEF to addr 4: strobe only in cycle n+2
    tick();
    n = cyc; w0 = we_cnt;
    drive(REQ_DMA, 1'b1, 1'b1, 32'd4, 32'hDEAD_BEEF);
    push_exp(REQ_DMA, 1'b0, 32'h0, n + 3);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 2) begin
        chk("dma_wr_strobe", 32'(mem_we), 32'h1);
        chk("dma_wr_addr",   mem_addr, 32'd4);
        chk("dma_wr_data",   mem_wdata, 32'hDEAD_BEEF);
      end else begin
        chk("dma_wr_no_strobe", 32'(mem_we), 32'h0);
      end
      tick();
    end
    wait_ack(2);
    tick();
    drive(REQ_DMA, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("dma_wr_strobe_count", 32'(we_cnt - w0), 32'h1);
    do_access(REQ_CPU, 1'b0, 32'd4, 32'h0, 32'hDEAD_BEEF, 1'b0);

    // vector table: single accesses, legal and rejected
    foreach (vecs[i]) begin
      do_access(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                vecs[i].exp_rdata, vecs[i].exp_err);
    end

    // Ties straight after reset: CPU first, then DMA; then a CPU request
    // held across into IDLE ties with the pending DMA and loses.
    apply_reset();
    tick();
    n = cyc;
    drive(REQ_CPU, 1'b1, 1'b0, 32'd8, 32'h0);
    drive(REQ_DMA, 1'b1, 1'b0, 32'd0, 32'h0);
    push_exp(REQ_CPU, 1'b0, 32'h1234_5678, n + 3);
    push_exp(REQ_DMA, 1'b0, init_word(0), n + 7);
    wait_ack(8);
    tick();
    drive(REQ_CPU, 1'b1, 1'b0, 32'd12, 32'h0);
    push_exp(REQ_CPU, 1'b0, init_word(3), n + 11);
    wait_ack(8);
    tick();
    drive(REQ_DMA, 1'b0, 1'b0, 32'h0, 32'h0);
    wait_ack(8);
    tick();
    drive(REQ_CPU, 1'b0, 1'b0, 32'h0, 32'h0);

    // Reset in the first ACCESS cycle of a write: strobes drop at once,
    // no ack, memory keeps its old word.
    tick();
    drive(REQ_CPU, 1'b1, 1'b1, 32'd16, 32'h55AA_55AA);
    tick();
    @(negedge clk);
    chk("pre_reset_mem_en", 32'(mem_en), 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_mem_en", 32'(mem_en), 32'h0);
    chk("async_rst_mem_we", 32'(mem_we), 32'h0);
    chk("async_rst_state",  32'(dbg_state), 32'(IDLE));
    drive(REQ_CPU, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    rst = 1'b0;
    a0 = ack_cnt;
    repeat (6) tick();
    chk("no_ack_after_reset", 32'(ack_cnt - a0), 32'h0);
    do_access(REQ_CPU, 1'b0, 32'd16, 32'h0, init_word(4), 1'b0);

    // Requester drops req during ACCESS: one access, one ack.
    tick();
    n = cyc; e0 = en_cnt; a0 = ack_cnt;
    drive(REQ_DMA, 1'b1, 1'b0, 32'd12, 32'h0);
    push_exp(REQ_DMA, 1'b0, init_word(3), n + 3);
    tick();
    drive(REQ_DMA, 1'b0, 1'b0, 32'h0, 32'h0);
    wait_ack(6);
    repeat (6) tick();
    chk("drop_req_en_cycles", 32'(en_cnt - e0), 32'(LAT));
    chk("drop_req_ack_count", 32'(ack_cnt - a0), 32'h1);
    chk("dma_rdata_hold",     dma_rdata, init_word(3));

    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
